// File: rtl/hv_accum_ctrl_pkg.sv
// Shared types and constants for the hypervector accumulator controller.
// Lane values are two's-complement counters packed LSB-first in each memory word.
package hv_pkg;

  typedef enum logic [1:0] {
    OP_ACC  = 2'd0,
    OP_LOAD = 2'd1,
    OP_CLR  = 2'd2,
    OP_READ = 2'd3
  } op_t;

  localparam int DEF_LANES = 4;
  localparam int DEF_CNT_W = 4;

  localparam logic signed [DEF_CNT_W-1:0] CNT_MAX = {1'b0, {(DEF_CNT_W-1){1'b1}}};
  localparam logic signed [DEF_CNT_W-1:0] CNT_MIN = {1'b1, {(DEF_CNT_W-1){1'b0}}};

  function automatic logic [DEF_CNT_W-1:0] lane_get(
    input logic [DEF_LANES*DEF_CNT_W-1:0] word,
    input int                              idx
  );
    return word[idx*DEF_CNT_W +: DEF_CNT_W];
  endfunction

endpackage

// File: rtl/hv_lane_sat_add.sv
// Signed +/-1 saturating step for one counter lane; combinational.
// clip is set when the step would leave the representable range and the value is held.
module hv_lane_sat_add
  import hv_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic [CNT_W-1:0] old_cnt,
  input  logic             up,
  output logic [CNT_W-1:0] new_cnt,
  output logic             clip
);

  localparam logic [CNT_W-1:0] MAX_V = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] MIN_V = {1'b1, {(CNT_W-1){1'b0}}};

  assign clip    = up ? (old_cnt == MAX_V) : (old_cnt == MIN_V);
  assign new_cnt = clip ? old_cnt : (up ? old_cnt + 1'b1 : old_cnt - 1'b1);

endmodule

// File: rtl/hv_accum_ctrl.sv
// Read-modify-write controller for packed hypervector counters: port 0 reads, port 1 writes.
// One command per cycle, result/write one cycle after accept; never backpressures outside reset.
module hv_accum_ctrl
  import hv_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LANES      = DEF_LANES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int DATA_WIDTH = LANES * CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [LANES-1:0]      in_bits,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [LANES-1:0]      out_hv,
  output logic                  sat_pulse,
  output logic [15:0]           acc_count,
  output logic [ADDR_WIDTH-1:0] mem_addr_0,
  output logic                  mem_cs_0,
  output logic                  mem_we_0,
  output logic                  mem_oe_0,
  input  logic [DATA_WIDTH-1:0] mem_rdata_0,
  output logic [ADDR_WIDTH-1:0] mem_addr_1,
  output logic [DATA_WIDTH-1:0] mem_wdata_1,
  output logic                  mem_cs_1,
  output logic                  mem_we_1,
  output logic                  mem_oe_1
);

  logic                  s1_vld;
  op_t                   s1_op;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [LANES-1:0]      s1_bits;

  logic                  fwd_vld;
  logic [ADDR_WIDTH-1:0] fwd_addr;
  logic [DATA_WIDTH-1:0] fwd_data;

  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] acc_word;
  logic [DATA_WIDTH-1:0] load_word;
  logic [DATA_WIDTH-1:0] new_word;
  logic [LANES-1:0]      clip;
  logic [LANES-1:0]      bin_hv;
  logic                  s1_wr;
  logic                  s1_acc;
  logic                  s0_rd;

  // Stage 0: issue the read for everything that needs the old word.
  assign in_ready   = ~rst;
  assign s0_rd      = ~rst & in_valid & (op_t'(in_op) != OP_CLR);
  assign mem_cs_0   = s0_rd;
  assign mem_we_0   = 1'b0;
  assign mem_oe_0   = s0_rd;
  assign mem_addr_0 = s0_rd ? in_addr : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_op     <= OP_ACC;
      s1_addr   <= '0;
      s1_bits   <= '0;
      fwd_vld   <= 1'b0;
      fwd_addr  <= '0;
      fwd_data  <= '0;
      acc_count <= '0;
    end else begin
      s1_vld   <= in_valid;
      s1_op    <= op_t'(in_op);
      s1_addr  <= in_addr;
      s1_bits  <= in_bits;
      fwd_vld  <= s1_wr;
      fwd_addr <= s1_addr;
      fwd_data <= new_word;
      if (s1_acc && (acc_count != 16'hFFFF)) begin
        acc_count <= acc_count + 16'd1;
      end
    end
  end

  // The memory returns pre-write data for a same-edge read, so the last write is bypassed in.
  assign fwd_hit  = fwd_vld & (fwd_addr == s1_addr);
  assign old_word = fwd_hit ? fwd_data : mem_rdata_0;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    hv_lane_sat_add #(.CNT_W(CNT_W)) u_sat (
      .old_cnt (old_word[i*CNT_W +: CNT_W]),
      .up      (s1_bits[i]),
      .new_cnt (acc_word[i*CNT_W +: CNT_W]),
      .clip    (clip[i])
    );
    assign load_word[i*CNT_W +: CNT_W] = {{(CNT_W-1){~s1_bits[i]}}, 1'b1};
    assign bin_hv[i] = ~old_word[i*CNT_W + CNT_W - 1];
  end

  always_comb begin
    new_word = '0;
    case (s1_op)
      OP_ACC:  new_word = acc_word;
      OP_LOAD: new_word = load_word;
      default: new_word = '0;
    endcase
  end

  assign s1_wr  = s1_vld & (s1_op != OP_READ);
  assign s1_acc = s1_vld & (s1_op == OP_ACC);

  assign mem_cs_1    = s1_wr;
  assign mem_we_1    = s1_wr;
  assign mem_oe_1    = 1'b0;
  assign mem_addr_1  = s1_wr ? s1_addr : '0;
  assign mem_wdata_1 = s1_wr ? new_word : '0;
  assign sat_pulse   = s1_acc & (|clip);

  assign out_valid = s1_vld & (s1_op == OP_READ);
  assign out_addr  = out_valid ? s1_addr : '0;
  assign out_hv    = out_valid ? bin_hv : '0;

endmodule

// File: tb/tb_hv_accum_ctrl.sv
// Directed bench for hv_accum_ctrl with a behavioural 1-cycle-read dual-port memory.
module tb_hv_accum_ctrl;
  import hv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'd0;
  logic [7:0]  in_addr = 8'd0;
  logic [3:0]  in_bits = 4'd0;
  logic        out_valid;
  logic [7:0]  out_addr;
  logic [3:0]  out_hv;
  logic        sat_pulse;
  logic [15:0] acc_count;
  logic [7:0]  mem_addr_0;
  logic        mem_cs_0, mem_we_0, mem_oe_0;
  logic [15:0] mem_rdata_0 = 16'd0;
  logic [7:0]  mem_addr_1;
  logic [15:0] mem_wdata_1;
  logic        mem_cs_1, mem_we_1, mem_oe_1;

  logic [15:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  logic        cap_wr, cap_sat, cap_ov;
  logic [15:0] cap_wdata;
  logic [7:0]  cap_waddr, cap_oaddr;
  logic [3:0]  cap_ohv;

  hv_accum_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_addr(in_addr), .in_bits(in_bits),
    .out_valid(out_valid), .out_addr(out_addr), .out_hv(out_hv),
    .sat_pulse(sat_pulse), .acc_count(acc_count),
    .mem_addr_0(mem_addr_0), .mem_cs_0(mem_cs_0), .mem_we_0(mem_we_0),
    .mem_oe_0(mem_oe_0), .mem_rdata_0(mem_rdata_0),
    .mem_addr_1(mem_addr_1), .mem_wdata_1(mem_wdata_1), .mem_cs_1(mem_cs_1),
    .mem_we_1(mem_we_1), .mem_oe_1(mem_oe_1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_cs_0 && mem_oe_0 && !mem_we_0) mem_rdata_0 <= mem[mem_addr_0];
    if (mem_cs_1 && mem_we_1) mem[mem_addr_1] <= mem_wdata_1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one command for a cycle and capture the stage-1 view of it.
  task automatic send(input op_t op, input logic [7:0] addr, input logic [3:0] bits);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_addr  = addr;
    in_bits  = bits;
    @(posedge clk);
    #1;
    cap_wr    = mem_cs_1 & mem_we_1;
    cap_waddr = mem_addr_1;
    cap_wdata = mem_wdata_1;
    cap_sat   = sat_pulse;
    cap_ov    = out_valid;
    cap_oaddr = out_addr;
    cap_ohv   = out_hv;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  logic [15:0] exp_w;
  int          v;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'd0;
    in_valid = 1'b1;
    in_op    = OP_ACC;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cs0", mem_cs_0, 0);
    chk("rst_cs1", mem_cs_1, 0);
    chk("rst_acc_count", acc_count, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("in_ready_up", in_ready, 1);

    // Accumulate with forwarding on every beat
    send(OP_CLR, 8'd5, 4'b0000);
    chk("t1_clr_wr", {cap_wr, cap_wdata}, {1'b1, 16'h0000});
    send(OP_ACC, 8'd5, 4'b1011);
    chk("t1_acc1", cap_wdata, 16'h1F11);
    send(OP_ACC, 8'd5, 4'b1011);
    chk("t1_acc2", cap_wdata, 16'h2E22);
    send(OP_ACC, 8'd5, 4'b1011);
    chk("t1_acc3", cap_wdata, 16'h3D33);
    send(OP_READ, 8'd5, 4'b0000);
    chk("t1_read", {cap_ov, cap_oaddr, cap_ohv}, {1'b1, 8'd5, 4'b1011});
    chk("t1_acc_count", acc_count, 3);

    // Saturation at the negative limit
    send(OP_LOAD, 8'd2, 4'b0000);
    chk("t2_load", cap_wdata, 16'hFFFF);
    for (int k = 1; k <= 8; k++) begin
      send(OP_ACC, 8'd2, 4'b0000);
      v = -1 - k;
      if (v < int'(CNT_MIN)) v = int'(CNT_MIN);
      exp_w = {4{4'(v)}};
      chk($sformatf("t2_acc%0d_w", k), cap_wdata, exp_w);
      chk($sformatf("t2_acc%0d_sat", k), cap_sat, (k == 8));
    end
    send(OP_READ, 8'd2, 4'b0000);
    chk("t2_read", {cap_ov, cap_ohv}, {1'b1, 4'b0000});
    chk("t2_acc_count", acc_count, 11);

    // Tie maps to 1; single-cycle result pulse, no write for READ
    send(OP_CLR, 8'd9, 4'b0101);
    chk("t3_clr_no_ov", cap_ov, 0);
    @(negedge clk);
    in_op   = OP_READ;
    in_addr = 8'd9;
    #1;
    chk("t3_port0", {mem_cs_0, mem_oe_0, mem_we_0, mem_addr_0}, {3'b110, 8'd9});
    @(posedge clk);
    #1;
    chk("t3_read", {out_valid, out_addr, out_hv}, {1'b1, 8'd9, 4'b1111});
    chk("t3_port1_idle", {mem_cs_1, mem_we_1}, 2'b00);
    idle(1);
    @(posedge clk);
    #1;
    chk("t3_pulse_single", out_valid, 0);

    // Interleaved addresses must not forward across each other
    send(OP_CLR, 8'd1, 4'b0000);
    send(OP_CLR, 8'd2, 4'b0000);
    for (int k = 0; k < 10; k++) send(OP_ACC, (k % 2 == 1) ? 8'd2 : 8'd1, 4'b1111);
    idle(2);
    chk("t4_word1", mem[1], 16'h5555);
    chk("t4_word2", mem[2], 16'h5555);
    chk("t4_acc_count", acc_count, 21);

    // LOAD then READ through the forward path
    send(OP_LOAD, 8'd3, 4'b1100);
    chk("t6_load_w", cap_wdata, 16'h11FF);
    send(OP_READ, 8'd3, 4'b0000);
    chk("t6_read", {cap_ov, cap_ohv}, {1'b1, 4'b1100});
    idle(2);
    chk("t6_mem", mem[3], 16'h11FF);

    // Reset while an ACC sits in stage 1
    send(OP_LOAD, 8'd7, 4'b1010);
    idle(2);
    chk("t5_pre", mem[7], 16'h1F1F);
    send(OP_ACC, 8'd7, 4'b1111);
    chk("t5_wr_pending", cap_wr, 1);
    rst = 1'b1;
    #1;
    chk("t5_outs_zero", {in_ready, out_valid, sat_pulse, mem_cs_0, mem_oe_0, mem_cs_1, mem_we_1},
        7'b0);
    chk("t5_count_zero", acc_count, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("t5_mem_unchanged", mem[7], 16'h1F1F);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    idle(1);
    chk("t5_after_count", acc_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hv_accum_ctrl.md
Name: hv_accum_ctrl

Overview:
- Read-modify-write controller that sits directly upstream of the dual-port hypervector memory (memory_double).
- Accepts a stream of encoded hypervector chunks and updates packed signed per-dimension counters (the class accumulators).
- Port 0 of the memory is used only for reads; port 1 only for writes.
- Also supports clearing, loading, and binarized read-out of any word.

Parameters:
- ADDR_WIDTH, 8, memory address width.
- LANES, 4, dimensions (counters) per memory word.
- CNT_W, 4, signed counter width per lane.
- DATA_WIDTH, LANES*CNT_W (16), memory word width; must equal the memory data width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid && in_ready
- in_op  in  2  0=ACC, 1=LOAD, 2=CLR, 3=READ
- in_addr  in  ADDR_WIDTH  target word
- in_bits  in  LANES  hypervector chunk; bit i=1 means +1, bit i=0 means -1
- out_valid  out  1  read-out result valid (single-cycle pulse)
- out_addr  out  ADDR_WIDTH  address of the read-out word
- out_hv  out  LANES  binarized read-out
- sat_pulse  out  1  at least one lane clipped on this write
- acc_count  out  16  number of ACC commands completed; saturates at 0xFFFF
- mem_addr_0  out  ADDR_WIDTH;  mem_cs_0 / mem_we_0 / mem_oe_0  out  1 each;  mem_rdata_0  in  DATA_WIDTH
- mem_addr_1  out  ADDR_WIDTH;  mem_wdata_1  out  DATA_WIDTH;  mem_cs_1 / mem_we_1 / mem_oe_1  out  1 each

Behaviour:
- Reset (async, rst=1): all outputs 0, including in_ready, all mem strobes, and acc_count. The pipeline is flushed. A command in flight is dropped and its write never issues.
- in_ready = 1 whenever rst=0. Throughput is one command per cycle, with no stalls.
- Stage 0 (accept cycle t):
  - ACC, LOAD and READ drive mem_cs_0=1, mem_we_0=0, mem_oe_0=1, mem_addr_0=in_addr.
  - CLR does not drive port 0.
  - Otherwise mem_cs_0=0.
  - The command is registered into stage 1.
- Stage 1 (cycle t+1): mem_rdata_0 holds the old word, because the memory read latency is 1.
  - old = fwd_hit ? fwd_data : mem_rdata_0.
  - fwd_hit = the previous cycle's stage-1 write is valid and its address equals this address.
  - This covers back-to-back commands to the same address. Without it the memory would return the pre-write value, since a same-edge read returns old data.
- ACC: for each lane, new_i = sat(old_i + (bit_i ? +1 : -1)).
  - Range is signed [-2^(CNT_W-1), 2^(CNT_W-1)-1], i.e. [-8, 7] by default.
  - Clipping holds the value at the limit and asserts sat_pulse in the write cycle.
  - acc_count increments on the write.
- LOAD: new_i = bit_i ? +1 : -1. The read data is ignored.
- CLR: new = 0.
- Writes for ACC, LOAD and CLR happen in stage 1: mem_cs_1=1, mem_we_1=1, mem_oe_1=0, mem_addr_1=addr, mem_wdata_1=new. The forward register captures addr and new.
- READ: no write (mem_cs_1=0). In cycle t+1, out_valid=1, out_addr=addr, and out_hv_i = (old_i >= 0). A tie (0) maps to 1. The read uses forwarded data when fwd_hit.
- Port 1 is deasserted (cs=we=0) whenever no write occurs.
- Lane i occupies word bits [i*CNT_W +: CNT_W], with lane 0 at the LSBs.
- Latency: a command accepted at t produces its write or result in cycle t+1. The write is visible in memory from t+2.
- Ports 0 and 1 never address the same word with opposite intent in a way that matters; forwarding makes results order-correct.

Decomposition:
- Package hv_pkg holds:
  - the op enum typedef (OP_ACC, OP_LOAD, OP_CLR, OP_READ);
  - default LANES and CNT_W;
  - CNT_MAX and CNT_MIN constants;
  - a lane-slice helper function.
- One sub-module, hv_lane_sat_add: a combinational per-lane signed ±1 saturating adder with a clip flag, instantiated LANES times.

Test Plan:
1. CLR addr 5, then 3 back-to-back ACC with bits=4'b1011 on addr 5, then READ 5.
   - Word = lanes {+3,-3,+3,+3}; out_hv=1011.
   - Confirms forwarding on every beat. acc_count=3.
2. LOAD addr 2 bits=0000, then 8 consecutive ACC bits=0000.
   - Lanes stick at -8 (0x8888).
   - sat_pulse=1 on the last ACC only (the first seven reach -8 exactly on the 7th).
   - READ gives out_hv=0000.
3. CLR addr 9, then READ 9.
   - out_hv=1111 (tie maps to 1).
   - out_valid asserts exactly one cycle after accept; port 1 stays idle for the READ.
4. Alternate ACC addr 1 / ACC addr 2 for 10 cycles with bits=1111.
   - No false forwarding; each word ends at +5 per lane (0x5555).
5. Assert rst while ACC addr 7 is in stage 1.
   - No port-1 write issues; all outputs are 0 during reset; word 7 is unchanged.
6. LOAD addr 3 bits=1100 followed immediately by READ 3.
   - out_hv=1100 via the forward path; memory word is 0x11FF.
